// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
// Non-memory results pass straight through to writeback. LW/LB/LBU/SW/SB
// perform one access on a req/ack bus while the upstream stage is stalled.
// Every output is taken directly from a register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_wd_i,
    input  logic        ex_wreg_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [2:0]  ex_memop_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_sdata_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        align_err_o,
    output logic        bus_err_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;

    // The access gives up in the WAIT cycle whose increment would reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Big-endian lane select: offset 0 is bits 31:24.
    function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] sel_v;
        if ((op == OP_LW) || (op == OP_SW)) begin
            sel_v = 4'b1111;
        end else begin
            sel_v = 4'b1000 >> off;
        end
        return sel_v;
    endfunction

    // Shape the returned bus word into the writeback value for a load.
    function automatic logic [31:0] load_result(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] shifted_v;
        logic [7:0]  byte_v;
        logic [31:0] res_v;
        shifted_v = rdata >> {(2'b11 - off), 3'b000};
        byte_v    = shifted_v[7:0];
        case (op)
            OP_LW:   res_v = rdata;
            OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  res_v = {24'h00_0000, byte_v};
            default: res_v = 32'h0000_0000;
        endcase
        return res_v;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [4:0]  lat_wd_r, lat_wd_s;
    logic        lat_wreg_r, lat_wreg_s;
    logic [2:0]  lat_op_r, lat_op_s;
    logic [1:0]  lat_off_r, lat_off_s;

    logic        stall_r, stall_s;
    logic        req_r, req_s;
    logic        we_r, we_s;
    logic [31:0] addr_r, addr_s;
    logic [3:0]  sel_r, sel_s;
    logic [31:0] mwdata_r, mwdata_s;
    logic        wb_valid_r, wb_valid_s;
    logic [4:0]  wb_wd_r, wb_wd_s;
    logic        wb_wreg_r, wb_wreg_s;
    logic [31:0] wb_wdata_r, wb_wdata_s;
    logic        align_err_r, align_err_s;
    logic        bus_err_r, bus_err_s;

    logic        is_word_s;
    logic        is_store_s;
    logic        is_store_lat_s;

    // Next-state and next-output logic for the IDLE/WAIT access controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        lat_wd_s    = lat_wd_r;
        lat_wreg_s  = lat_wreg_r;
        lat_op_s    = lat_op_r;
        lat_off_s   = lat_off_r;
        req_s       = req_r;
        we_s        = we_r;
        addr_s      = addr_r;
        sel_s       = sel_r;
        mwdata_s    = mwdata_r;
        wb_valid_s  = 1'b0;
        wb_wd_s     = wb_wd_r;
        wb_wreg_s   = 1'b0;
        wb_wdata_s  = wb_wdata_r;
        align_err_s = 1'b0;
        bus_err_s   = 1'b0;

        is_word_s      = (ex_memop_i == OP_LW) || (ex_memop_i == OP_SW);
        is_store_s     = (ex_memop_i == OP_SW) || (ex_memop_i == OP_SB);
        is_store_lat_s = (lat_op_r == OP_SW) || (lat_op_r == OP_SB);

        case (state_r)
            IDLE: begin
                if (ex_valid_i) begin
                    case (ex_memop_i)
                        OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: begin
                            if (is_word_s && (ex_addr_i[1:0] != 2'b00)) begin
                                wb_valid_s  = 1'b1;
                                wb_wd_s     = ex_wd_i;
                                wb_wreg_s   = 1'b0;
                                wb_wdata_s  = 32'h0000_0000;
                                align_err_s = 1'b1;
                            end else begin
                                state_s    = WAIT;
                                cnt_s      = 8'd0;
                                lat_wd_s   = ex_wd_i;
                                lat_wreg_s = ex_wreg_i;
                                lat_op_s   = ex_memop_i;
                                lat_off_s  = ex_addr_i[1:0];
                                req_s      = 1'b1;
                                we_s       = is_store_s;
                                addr_s     = {ex_addr_i[31:2], 2'b00};
                                sel_s      = lane_sel(ex_memop_i, ex_addr_i[1:0]);
                                if (ex_memop_i == OP_SB) begin
                                    mwdata_s = {4{ex_sdata_i[7:0]}};
                                end else begin
                                    mwdata_s = ex_sdata_i;
                                end
                            end
                        end
                        default: begin
                            wb_valid_s = 1'b1;
                            wb_wd_s    = ex_wd_i;
                            wb_wreg_s  = ex_wreg_i;
                            wb_wdata_s = ex_wdata_i;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    wb_valid_s = 1'b1;
                    wb_wd_s    = lat_wd_r;
                    if (is_store_lat_s) begin
                        wb_wreg_s  = 1'b0;
                        wb_wdata_s = 32'h0000_0000;
                    end else begin
                        wb_wreg_s  = lat_wreg_r;
                        wb_wdata_s = load_result(lat_op_r, lat_off_r, mem_rdata_i);
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_s    = IDLE;
                    cnt_s      = cnt_r + 8'd1;
                    req_s      = 1'b0;
                    wb_valid_s = 1'b1;
                    wb_wd_s    = lat_wd_r;
                    wb_wreg_s  = 1'b0;
                    wb_wdata_s = 32'h0000_0000;
                    bus_err_s  = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase

        stall_s = (state_s == WAIT);
    end

    // State, latched instruction fields and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            lat_wd_r    <= 5'd0;
            lat_wreg_r  <= 1'b0;
            lat_op_r    <= 3'd0;
            lat_off_r   <= 2'd0;
            stall_r     <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            sel_r       <= 4'b0000;
            mwdata_r    <= 32'h0000_0000;
            wb_valid_r  <= 1'b0;
            wb_wd_r     <= 5'd0;
            wb_wreg_r   <= 1'b0;
            wb_wdata_r  <= 32'h0000_0000;
            align_err_r <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            lat_wd_r    <= lat_wd_s;
            lat_wreg_r  <= lat_wreg_s;
            lat_op_r    <= lat_op_s;
            lat_off_r   <= lat_off_s;
            stall_r     <= stall_s;
            req_r       <= req_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            sel_r       <= sel_s;
            mwdata_r    <= mwdata_s;
            wb_valid_r  <= wb_valid_s;
            wb_wd_r     <= wb_wd_s;
            wb_wreg_r   <= wb_wreg_s;
            wb_wdata_r  <= wb_wdata_s;
            align_err_r <= align_err_s;
            bus_err_r   <= bus_err_s;
        end
    end

    assign stall_o     = stall_r;
    assign mem_req_o   = req_r;
    assign mem_we_o    = we_r;
    assign mem_addr_o  = addr_r;
    assign mem_sel_o   = sel_r;
    assign mem_wdata_o = mwdata_r;
    assign wb_valid_o  = wb_valid_r;
    assign wb_wd_o     = wb_wd_r;
    assign wb_wreg_o   = wb_wreg_r;
    assign wb_wdata_o  = wb_wdata_r;
    assign align_err_o = align_err_r;
    assign bus_err_o   = bus_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// reset/idle sequences, and randomized instructions against a reference model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  ex_wd_i;
    logic        ex_wreg_i;
    logic [31:0] ex_wdata_i;
    logic [2:0]  ex_memop_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_sdata_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        wb_valid_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        align_err_o;
    logic        bus_err_o;

    int tests = 0;
    int fails = 0;
    logic [4:0] hold_wd = 5'd0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i),
        .ex_wdata_i(ex_wdata_i), .ex_memop_i(ex_memop_i), .ex_addr_i(ex_addr_i),
        .ex_sdata_i(ex_sdata_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .wb_valid_o(wb_valid_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
        .wb_wdata_o(wb_wdata_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_at;   // WAIT cycle carrying ack, 0 = never
        logic        e_access;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [31:0] e_mwdata;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_align;
        logic        e_bus;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t tv(input logic [2:0] op, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at,
                                input logic e_access, input logic [3:0] e_sel, input logic e_we,
                                input logic [31:0] e_mwdata, input logic e_wreg,
                                input logic [31:0] e_wdata, input logic e_align, input logic e_bus);
        vec_t v;
        v.op = op; v.wd = wd; v.wreg = wreg; v.wdata = wdata; v.addr = addr;
        v.sdata = sdata; v.rdata = rdata; v.ack_at = ack_at; v.e_access = e_access;
        v.e_sel = e_sel; v.e_we = e_we; v.e_mwdata = e_mwdata; v.e_wreg = e_wreg;
        v.e_wdata = e_wdata; v.e_align = e_align; v.e_bus = e_bus;
        return v;
    endfunction

    // Reference model: expected behaviour from the stage's rules, in plain arithmetic.
    function automatic vec_t model(input logic [2:0] op, input logic [4:0] wd, input logic wreg,
                                   input logic [31:0] wdata, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at);
        vec_t v;
        int off;
        int b;
        bit is_mem, is_word, is_store;
        off      = int'(addr) & 3;
        is_mem   = (op >= 3'd1) && (op <= 3'd5);
        is_word  = (op == 3'd1) || (op == 3'd4);
        is_store = (op == 3'd4) || (op == 3'd5);
        v = tv(op, wd, wreg, wdata, addr, sdata, rdata, ack_at,
               1'b0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        if (!is_mem) begin
            v.e_wreg  = wreg;
            v.e_wdata = wdata;
        end else if (is_word && off != 0) begin
            v.e_align = 1'b1;
        end else begin
            v.e_access = 1'b1;
            v.e_sel    = is_word ? 4'hF : 4'(8 >> off);
            v.e_we     = is_store;
            v.e_mwdata = (op == 3'd5) ? (sdata & 32'hFF) * 32'h0101_0101 : sdata;
            v.e_bus    = !(ack_at >= 1 && ack_at <= TO);
            if (!v.e_bus && !is_store) begin
                v.e_wreg = wreg;
                b = int'((rdata / (32'd1 << (8 * (3 - off)))) % 32'd256);
                if (op == 3'd1)      v.e_wdata = rdata;
                else if (op == 3'd2) v.e_wdata = (b >= 128) ? 32'(b - 256) : 32'(b);
                else                 v.e_wdata = 32'(b);
            end
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, run its WAIT phase (if any) and check writeback.
    task automatic apply(input vec_t v);
        int  k;
        bit  done;
        ex_valid_i = 1'b1; ex_memop_i = v.op; ex_wd_i = v.wd; ex_wreg_i = v.wreg;
        ex_wdata_i = v.wdata; ex_addr_i = v.addr; ex_sdata_i = v.sdata;
        mem_ack_i  = 1'b0;
        step();
        if (v.e_access) begin
            done = 1'b0;
            k = 1;
            while (!done) begin
                chk("wait_stall", stall_o, 1);
                chk("wait_req", mem_req_o, 1);
                chk("wait_wb_valid", wb_valid_o, 0);
                chk("mem_addr", mem_addr_o, {v.addr[31:2], 2'b00});
                chk("mem_sel", mem_sel_o, v.e_sel);
                chk("mem_we", mem_we_o, v.e_we);
                if (v.e_we) chk("mem_wdata", mem_wdata_o, v.e_mwdata);
                // upstream presents its next (held) instruction; must be ignored
                ex_memop_i = 3'($urandom); ex_addr_i = $urandom; ex_wdata_i = $urandom;
                ex_wd_i = 5'($urandom);
                mem_ack_i   = (k == v.ack_at);
                mem_rdata_i = mem_ack_i ? v.rdata : $urandom;
                step();
                if (mem_ack_i || k == TO) done = 1'b1;
                k++;
                mem_ack_i = 1'b0;
            end
        end
        chk("wb_stall", stall_o, 0);
        chk("wb_req", mem_req_o, 0);
        chk("wb_valid", wb_valid_o, 1);
        chk("wb_wd", wb_wd_o, v.wd);
        chk("wb_wreg", wb_wreg_o, v.e_wreg);
        if (!v.e_bus) chk("wb_wdata", wb_wdata_o, v.e_wdata);
        chk("align_err", align_err_o, v.e_align);
        chk("bus_err", bus_err_o, v.e_bus);
        hold_wd = v.wd;
    endtask

    // One cycle with no instruction; a stray ack must be ignored.
    task automatic idle_cycle();
        ex_valid_i  = 1'b0;
        mem_ack_i   = 1'($urandom);
        mem_rdata_i = $urandom;
        step();
        mem_ack_i = 1'b0;
        chk("idle_wb_valid", wb_valid_o, 0);
        chk("idle_wb_wreg", wb_wreg_o, 0);
        chk("idle_wb_wd_hold", wb_wd_o, hold_wd);
        chk("idle_stall", stall_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_errs", {align_err_o, bus_err_o}, 0);
    endtask

    initial begin
        vec_t v;
        logic [2:0] rop;
        rst = 1'b1; ex_valid_i = 1'b0; ex_wd_i = 5'd0; ex_wreg_i = 1'b0;
        ex_wdata_i = 32'h0; ex_memop_i = 3'd0; ex_addr_i = 32'h0; ex_sdata_i = 32'h0;
        mem_rdata_i = 32'h0; mem_ack_i = 1'b0;

        // op wd wreg wdata addr sdata rdata ack | access sel we mwdata wreg wdata align bus
        tbl[0]  = tv(3'd0, 5'd3,  1'b1, 32'h1234_5678, 32'h0,   32'h0,        32'h0,        0, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tbl[1]  = tv(3'd2, 5'd5,  1'b1, 32'h0,         32'h101, 32'h0,        32'h11F2_2233, 3, 1'b1, 4'b0100, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0);
        tbl[2]  = tv(3'd3, 5'd6,  1'b1, 32'h0,         32'h101, 32'h0,        32'h11F2_2233, 3, 1'b1, 4'b0100, 1'b0, 32'h0,        1'b1, 32'h0000_00F2, 1'b0, 1'b0);
        tbl[3]  = tv(3'd5, 5'd7,  1'b1, 32'h0,         32'h203, 32'h0000_00AB, 32'h0,        1, 1'b1, 4'b0001, 1'b1, 32'hABAB_ABAB, 1'b0, 32'h0,         1'b0, 1'b0);
        tbl[4]  = tv(3'd1, 5'd9,  1'b1, 32'h0,         32'h6,   32'h0,        32'h0,        0, 1'b0, 4'h0,    1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0);
        tbl[5]  = tv(3'd1, 5'd10, 1'b1, 32'h0,         32'h40,  32'h0,        32'h0,        0, 1'b1, 4'hF,    1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 1'b1);
        tbl[6]  = tv(3'd1, 5'd11, 1'b1, 32'h0,         32'h40,  32'h0,        32'hDEAD_BEEF, 4, 1'b1, 4'hF,    1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tbl[7]  = tv(3'd4, 5'd12, 1'b1, 32'h0,         32'h44,  32'hCAFE_F00D, 32'h0,        2, 1'b1, 4'hF,    1'b1, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 1'b0);
        tbl[8]  = tv(3'd4, 5'd8,  1'b1, 32'h0,         32'h45,  32'h1,        32'h0,        0, 1'b0, 4'h0,    1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 1'b0);
        tbl[9]  = tv(3'd2, 5'd13, 1'b1, 32'h0,         32'h103, 32'h0,        32'h0000_007F, 1, 1'b1, 4'b0001, 1'b0, 32'h0,        1'b1, 32'h0000_007F, 1'b0, 1'b0);
        tbl[10] = tv(3'd6, 5'd31, 1'b0, 32'hA5A5_A5A5, 32'h7,   32'h0,        32'h0,        0, 1'b0, 4'h0,    1'b0, 32'h0,        1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        tbl[11] = tv(3'd7, 5'd1,  1'b1, 32'h0000_0042, 32'h2,   32'h0,        32'h0,        0, 1'b0, 4'h0,    1'b0, 32'h0,        1'b1, 32'h0000_0042, 1'b0, 1'b0);
        tbl[12] = tv(3'd2, 5'd14, 1'b0, 32'h0,         32'h0,   32'h0,        32'h80FF_FFFF, 2, 1'b1, 4'b1000, 1'b0, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
        tbl[13] = tv(3'd3, 5'd2,  1'b1, 32'h0,         32'h2,   32'h0,        32'h1234_AB78, 1, 1'b1, 4'b0010, 1'b0, 32'h0,        1'b1, 32'h0000_00AB, 1'b0, 1'b0);

        // Reset state
        repeat (3) step();
        chk("rst_outs", {stall_o, mem_req_o, mem_we_o, mem_sel_o, wb_valid_o, wb_wreg_o,
                         align_err_o, bus_err_o}, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_mwdata", mem_wdata_o, 0);
        chk("rst_wb_wd", wb_wd_o, 0);
        chk("rst_wb_wdata", wb_wdata_o, 0);
        rst = 1'b0;
        idle_cycle();

        // Directed table, back to back
        for (int i = 0; i < 14; i++) apply(tbl[i]);
        idle_cycle();

        // Reset in the 2nd WAIT cycle of a store
        ex_valid_i = 1'b1; ex_memop_i = 3'd4; ex_addr_i = 32'h80; ex_sdata_i = 32'h5555_AAAA;
        ex_wd_i = 5'd4; ex_wreg_i = 1'b1;
        step();
        ex_valid_i = 1'b0;
        chk("rst_seq_w1_req", mem_req_o, 1);
        step();
        chk("rst_seq_w2_req", mem_req_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_seq_outs", {stall_o, mem_req_o, mem_we_o, mem_sel_o, wb_valid_o, wb_wreg_o,
                             align_err_o, bus_err_o}, 0);
        chk("rst_seq_addr", mem_addr_o, 0);
        chk("rst_seq_mwdata", mem_wdata_o, 0);
        chk("rst_seq_wb_wdata", wb_wdata_o, 0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        step();
        mem_ack_i = 1'b0;
        chk("late_ack_wb_valid", wb_valid_o, 0);
        chk("late_ack_req", mem_req_o, 0);
        chk("late_ack_stall", stall_o, 0);
        hold_wd = 5'd0;
        idle_cycle();

        // Randomized instructions against the reference model
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            v = model(rop, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                      $urandom_range(0, 6));
            apply(v);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It takes the execute result plus a memory-operation code and either passes the ALU result straight to writeback or performs a single load/store over a req/ack data bus. While an access is outstanding it stalls the upstream pipeline. All outputs are registered.

## Interface
Parameters:
- TIMEOUT, default 255: maximum WAIT cycles without ack before the access is aborted (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: rst, synchronous, active-high
- ex_valid_i  in  1  execute-stage result valid this cycle
- ex_wd_i  in  5  destination register address
- ex_wreg_i  in  1  destination write enable
- ex_wdata_i  in  32  ALU result
- ex_memop_i  in  3  0 NONE, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB; 6 and 7 are treated as NONE
- ex_addr_i  in  32  effective byte address
- ex_sdata_i  in  32  store data
- stall_o  out  1  upstream must hold its current instruction
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_sel_o  out  4  byte lanes; bit 3 = bits 31:24
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid when mem_ack_i = 1
- mem_ack_i  in  1  access complete
- wb_valid_o  out  1  writeback entry valid
- wb_wd_o  out  5  writeback register address
- wb_wreg_o  out  1  writeback enable
- wb_wdata_o  out  32  writeback data
- align_err_o  out  1  one-cycle pulse: misaligned LW or SW
- bus_err_o  out  1  one-cycle pulse: bus timeout

## Operation
- States: IDLE and WAIT. stall_o = (state == WAIT), driven from a register.
- Inputs are sampled only in IDLE, when ex_valid_i = 1.
- NONE op: next cycle wb_valid_o = 1 and wb_wd/wreg/wdata = ex inputs. State stays IDLE.
- LW or SW with addr[1:0] != 0: no bus access.
  - Next cycle: wb_valid_o = 1, wb_wreg_o = 0, wb_wdata_o = 0, align_err_o = 1.
  - Byte ops are never misaligned.
- Other memory ops:
  - Latch wd, op and addr[1:0]; enter WAIT.
  - Bus outputs are registered, so mem_req_o = 1 from the first WAIT cycle.
  - mem_addr_o = {addr[31:2], 2'b00}.
  - mem_we_o = 1 for SW and SB.
- Byte lanes are big-endian: addr[1:0] = 0 selects bits 31:24, 3 selects bits 7:0.
  - LW/SW: mem_sel_o = 1111.
  - LB/LBU/SB: mem_sel_o = 1000 >> addr[1:0].
  - SB: the low byte of sdata is replicated into all four lanes of mem_wdata_o.
- Bus signals are held stable in WAIT until mem_ack_i. mem_ack_i is ignored outside WAIT.
- Ack in WAIT: drop mem_req_o, return to IDLE, and next cycle assert wb_valid_o with:
  - LW: wdata = rdata.
  - LB: selected byte, sign-extended.
  - LBU: selected byte, zero-extended.
  - Loads: wb_wreg_o = latched wreg.
  - Stores: wb_wreg_o = 0, wb_wdata_o = 0.
- Timeout: an 8-bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT with no ack: drop mem_req_o, return to IDLE.
  - Next cycle: wb_valid_o = 1, wb_wreg_o = 0, bus_err_o = 1.
  - An ack arriving in the timeout cycle wins: normal completion.
- wb_valid_o, align_err_o and bus_err_o are single-cycle pulses per instruction.
  - wb_wd_o and wb_wdata_o hold their last value when wb_valid_o = 0; wb_wreg_o is 0 when wb_valid_o = 0.

## Timing
- Reset: state IDLE and the counter cleared. Every output is 0, including stall_o, mem_req_o, mem_sel_o, mem_addr_o and all wb_* outputs.
- Reset mid-access: mem_req_o drops the next cycle with no completion and no error. A late ack is ignored.
- Latency:
  - NONE op or misaligned op: 1 cycle, ex to wb.
  - Memory op with ack in the first WAIT cycle: 2 cycles (capture, WAIT + ack, wb).
  - Each extra cycle without ack adds 1.
- Throughput: 1 instruction per cycle for non-memory ops. An instruction arriving during WAIT is held by the upstream stage and sampled in the first IDLE cycle after completion, with no bubble beyond the wait.
- stall_o is 1 exactly during WAIT cycles. It falls in the cycle after ack, the same cycle the wb result appears.

## Test plan
- Reset, then NONE op (wd = 3, wreg = 1, wdata = 0x12345678) -> one cycle later wb_valid = 1, wd = 3, wdata = 0x12345678; stall_o stays 0.
- LB addr = 0x101, bus returns rdata = 0x11F22233 with ack in the 3rd WAIT cycle -> req held for 3 cycles, mem_addr = 0x100, sel = 0100, stall high for 3 cycles, then wb_wdata = 0xFFFFFFF2. Same access with LBU -> wb_wdata = 0x000000F2.
- SB addr = 0x203, sdata = 0xAB -> sel = 0001, we = 1, wdata = 0xABABABAB; after ack wb_valid = 1 with wb_wreg = 0.
- LW addr = 0x6 -> no mem_req_o, align_err_o pulse, wb_valid = 1 with wb_wreg = 0, next instruction accepted the following cycle.
- LW with TIMEOUT = 4 and no ack -> req high for exactly 4 cycles, then bus_err_o and wb_valid pulse with wb_wreg = 0. Repeat with ack in the 4th cycle -> normal completion, no bus_err_o.
- Assert rst in the 2nd WAIT cycle of an SW -> req drops the next cycle, all outputs 0, a subsequent ack is ignored, no wb_valid pulse.
